// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared mode encodings and FSM states for the universal shift register
package shift_pkg;

  localparam logic [1:0] MODE_SHL  = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_ROTL = 2'b10;
  localparam logic [1:0] MODE_ROTR = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational single shift/rotate step with ejected bit
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] r,
  input  logic [1:0]       mode,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] r_next,
  output logic             out_bit
);

  always_comb begin
    r_next  = r;
    out_bit = 1'b0;
    case (mode)
      MODE_SHL: begin
        r_next  = {r[WIDTH-2:0], sin_l};
        out_bit = r[WIDTH-1];
      end
      MODE_SHR: begin
        r_next  = {sin_r, r[WIDTH-1:1]};
        out_bit = r[0];
      end
      MODE_ROTL: begin
        r_next  = {r[WIDTH-2:0], r[WIDTH-1]};
        out_bit = r[WIDTH-1];
      end
      default: begin
        r_next  = {r[0], r[WIDTH-1:1]};
        out_bit = r[0];
      end
    endcase
  end

endmodule

// File: rtl/shift_register_univ.sv
// rtl/shift_register_univ.sv - universal shift register with parallel load and burst-shift engine
module shift_register_univ
  import shift_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] PIN,
  input  logic             EN,
  input  logic [1:0]       MODE,
  input  logic             SIN_L,
  input  logic             SIN_R,
  input  logic             START,
  input  logic [CNT_W-1:0] NSHIFT,
  output logic [WIDTH-1:0] POUT,
  output logic             SOUT,
  output logic             BUSY,
  output logic             DONE
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] reg_q, reg_d;
  logic             sout_q, sout_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic [1:0]       step_mode;
  logic [WIDTH-1:0] step_r;
  logic             step_o;
  logic [CNT_W-1:0] nshift_c;

  // A running burst uses the mode captured at START; single steps use the live MODE.
  assign step_mode = (state_q == ST_RUN) ? mode_q : MODE;
  assign nshift_c  = (NSHIFT > CNT_MAX) ? CNT_MAX : NSHIFT;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .r      (reg_q),
    .mode   (step_mode),
    .sin_l  (SIN_L),
    .sin_r  (SIN_R),
    .r_next (step_r),
    .out_bit(step_o)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      reg_q   <= '0;
      sout_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      mode_q  <= MODE_SHL;
    end else begin
      state_q <= state_d;
      reg_q   <= reg_d;
      sout_q  <= sout_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    reg_d   = reg_q;
    sout_d  = sout_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    if (LOAD) begin
      // Loading during a burst aborts it silently.
      reg_d   = PIN;
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (state_q == ST_RUN) begin
      reg_d  = step_r;
      sout_d = step_o;
      cnt_d  = cnt_q - CNT_ONE;
      if (cnt_q <= CNT_ONE) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
    end else if (START) begin
      if (nshift_c == '0) begin
        done_d = 1'b1;
      end else begin
        mode_d  = MODE;
        cnt_d   = nshift_c;
        state_d = ST_RUN;
      end
    end else if (EN) begin
      reg_d  = step_r;
      sout_d = step_o;
    end
  end

  assign POUT = reg_q;
  assign SOUT = sout_q;
  assign BUSY = (state_q == ST_RUN);
  assign DONE = done_q;

endmodule

// File: tb/tb_shift_register_univ.sv
// tb/tb_shift_register_univ.sv - self-checking bench for shift_register_univ
module tb_shift_register_univ;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b1;
  logic       LOAD, EN, SIN_L, SIN_R, START;
  logic [7:0] PIN;
  logic [1:0] MODE;
  logic [3:0] NSHIFT;
  logic [7:0] POUT;
  logic       SOUT, BUSY, DONE;

  shift_register_univ #(.WIDTH(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .LOAD(LOAD), .PIN(PIN), .EN(EN), .MODE(MODE),
    .SIN_L(SIN_L), .SIN_R(SIN_R), .START(START), .NSHIFT(NSHIFT),
    .POUT(POUT), .SOUT(SOUT), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string      name;
    logic [7:0] pout;
    logic       sout;
    logic       busy;
    logic       done;
  } exp_t;

  typedef struct {
    logic       load;
    logic [7:0] pin;
    logic       en;
    logic [1:0] mode;
    logic       sin_l;
    logic       sin_r;
    logic       start;
    logic [3:0] nshift;
    logic [7:0] e_pout;
    logic       e_sout;
    logic       e_busy;
    logic       e_done;
  } vec_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic clr();
    LOAD = 0; PIN = 0; EN = 0; MODE = 2'b00; SIN_L = 0; SIN_R = 0; START = 0; NSHIFT = 0;
  endtask

  task automatic expect_out(input string name, input logic [7:0] p, input logic s, b, d);
    exp_t e;
    e.name = name; e.pout = p; e.sout = s; e.busy = b; e.done = d;
    sb.push_back(e);
  endtask

  task automatic check_pop();
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: no expected record queued");
    end else begin
      e = sb.pop_front();
      if ({POUT, SOUT, BUSY, DONE} !== {e.pout, e.sout, e.busy, e.done}) begin
        n_fail++;
        $display("FAIL %s: got pout=%h sout=%b busy=%b done=%b, required pout=%h sout=%b busy=%b done=%b",
                 e.name, POUT, SOUT, BUSY, DONE, e.pout, e.sout, e.busy, e.done);
      end
    end
  endtask

  task automatic cycle(input string name, input logic [7:0] p, input logic s, b, d);
    expect_out(name, p, s, b, d);
    @(posedge CLK);
    #1;
    check_pop();
  endtask

  vec_t       vecs[13];
  logic [7:0] r;
  logic       s;

  initial begin
    vecs[0]  = '{1'b1, 8'hA5, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 4'd0, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 8'h00, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 4'd0, 8'h4B, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 8'hA5, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 4'd0, 8'hA5, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 4'd0, 8'h52, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 8'h81, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 4'd0, 8'h81, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 4'd0, 8'hC0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 4'd0, 8'h81, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 4'd0, 8'h02, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 4'd0, 8'h81, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 4'd0, 8'h81, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 8'h5A, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 4'd0, 8'h5A, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 4'd0, 8'h5A, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 4'd0, 8'h5A, 1'b0, 1'b0, 1'b0};

    clr();
    #1 RST_N = 1'b0;
    expect_out("reset_async", 8'h00, 1'b0, 1'b0, 1'b0);
    #1 check_pop();
    @(negedge CLK);
    RST_N = 1'b1;

    for (int i = 0; i < 13; i++) begin
      LOAD = vecs[i].load; PIN = vecs[i].pin; EN = vecs[i].en; MODE = vecs[i].mode;
      SIN_L = vecs[i].sin_l; SIN_R = vecs[i].sin_r; START = vecs[i].start; NSHIFT = vecs[i].nshift;
      cycle($sformatf("vec%0d", i), vecs[i].e_pout, vecs[i].e_sout, vecs[i].e_busy, vecs[i].e_done);
    end

    // Burst rotl x3 with MODE/EN wiggled during RUN.
    clr(); LOAD = 1; PIN = 8'hA5;           cycle("burst_load", 8'hA5, 1'b0, 1'b0, 1'b0);
    clr(); START = 1; NSHIFT = 3; MODE = 2'b10; cycle("burst_start", 8'hA5, 1'b0, 1'b1, 1'b0);
    clr(); MODE = 2'b01; EN = 1;            cycle("burst_s1", 8'h4B, 1'b1, 1'b1, 1'b0);
    clr(); MODE = 2'b00; EN = 1;            cycle("burst_s2", 8'h96, 1'b0, 1'b1, 1'b0);
    clr(); MODE = 2'b11;                    cycle("burst_s3", 8'h2D, 1'b1, 1'b0, 1'b1);
    clr();                                  cycle("burst_done_clr", 8'h2D, 1'b1, 1'b0, 1'b0);

    // Abort by LOAD on the second BUSY cycle.
    clr(); LOAD = 1; PIN = 8'hA5;           cycle("abort_load", 8'hA5, 1'b1, 1'b0, 1'b0);
    clr(); START = 1; NSHIFT = 8; MODE = 2'b10; cycle("abort_start", 8'hA5, 1'b1, 1'b1, 1'b0);
    clr();                                  cycle("abort_s1", 8'h4B, 1'b1, 1'b1, 1'b0);
    clr(); LOAD = 1; PIN = 8'h3C;           cycle("abort_reload", 8'h3C, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      clr();                                cycle($sformatf("abort_idle%0d", i), 8'h3C, 1'b1, 1'b0, 1'b0);
    end

    // NSHIFT=9 clamps to 8; a second START mid-burst is ignored.
    clr(); LOAD = 1; PIN = 8'hA5;           cycle("clamp_load", 8'hA5, 1'b1, 1'b0, 1'b0);
    clr(); START = 1; NSHIFT = 9; MODE = 2'b10; cycle("clamp_start", 8'hA5, 1'b1, 1'b1, 1'b0);
    r = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      clr();
      if (i == 1) begin START = 1; NSHIFT = 2; MODE = 2'b00; end
      s = r[7];
      r = {r[6:0], r[7]};
      cycle($sformatf("clamp_s%0d", i), r, s, (i < 7), (i == 7));
    end
    clr();                                  cycle("clamp_after", 8'hA5, 1'b1, 1'b0, 1'b0);

    // START and EN together: only the burst runs.
    clr(); START = 1; NSHIFT = 1; MODE = 2'b01; EN = 1; cycle("start_en", 8'hA5, 1'b1, 1'b1, 1'b0);
    clr();                                  cycle("start_en_s1", 8'h52, 1'b1, 1'b0, 1'b1);
    clr();                                  cycle("start_en_after", 8'h52, 1'b1, 1'b0, 1'b0);

    // Reset mid-burst: immediate clear, no DONE afterwards.
    clr(); LOAD = 1; PIN = 8'hA5;           cycle("rst_load", 8'hA5, 1'b1, 1'b0, 1'b0);
    clr(); START = 1; NSHIFT = 5; MODE = 2'b10; cycle("rst_start", 8'hA5, 1'b1, 1'b1, 1'b0);
    clr();                                  cycle("rst_s1", 8'h4B, 1'b1, 1'b1, 1'b0);
    #3 RST_N = 1'b0;
    expect_out("rst_mid_burst", 8'h00, 1'b0, 1'b0, 1'b0);
    #1 check_pop();
    @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle($sformatf("rst_after%0d", i), 8'h00, 1'b0, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_register_univ.md
Name: shift_register_univ

Overview:
Parametrised universal shift register, the next generation of our 4-bit load/shift register. Supports generic width, four shift modes (shift left, shift right, rotate left, rotate right) and parallel load. Adds an autonomous burst-shift engine: after one START it performs N shifts with BUSY/DONE handshaking. It sits between parallel data sources and serial links, and serves as a general datapath bit-mover.

Parameters:
WIDTH, 8, register width in bits (>= 2).
CNT_W, $clog2(WIDTH+1), derived localparam; width of the burst count.

Ports:
CLK     input   1        clock, rising edge active
RST_N   input   1        reset, asynchronous, active-low
LOAD    input   1        parallel load enable
PIN     input   WIDTH    parallel load data
EN      input   1        single-step shift enable
MODE    input   2        00 shl, 01 shr, 10 rotl, 11 rotr
SIN_L   input   1        serial in; enters bit 0 on shl
SIN_R   input   1        serial in; enters bit WIDTH-1 on shr
START   input   1        burst request
NSHIFT  input   CNT_W    burst length, 0..WIDTH
POUT    output  WIDTH    register contents
SOUT    output  1        bit ejected by the most recent shift or rotate
BUSY    output  1        burst in progress
DONE    output  1        one-cycle pulse when a burst completes

Behaviour:
- Reset (RST_N low, asynchronous): POUT=0, SOUT=0, BUSY=0, DONE=0, count=0, FSM to IDLE. Releasing reset mid-burst leaves the block in IDLE; no DONE is issued.
- All state is registered with non-blocking updates. Outputs reflect the cycle after the triggering edge.
- Per-edge priority: LOAD > burst step > START > EN > hold.
- LOAD: POUT<=PIN; SOUT unchanged.
  - If BUSY, the burst aborts: BUSY<=0, no DONE.
- One shift step with current register R:
  - shl: R<={R[W-2:0],SIN_L}, SOUT<=R[W-1].
  - shr: R<={SIN_R,R[W-1:1]}, SOUT<=R[0].
  - rotl: R<={R[W-2:0],R[W-1]}, SOUT<=R[W-1].
  - rotr: R<={R[0],R[W-1:1]}, SOUT<=R[0].
- EN (IDLE only, no LOAD/START): exactly one step using the live MODE. EN is ignored while BUSY.
- FSM has two states, IDLE and RUN.
  - In IDLE, START with NSHIFT>0: latch MODE, count<=NSHIFT, go to RUN, BUSY=1 next cycle. No shift occurs on the START edge.
  - In RUN, each edge performs one step with the latched mode and decrements count. When count reaches 1 on an edge: go to IDLE, BUSY<=0, DONE<=1 on that same edge. N shifts therefore take N cycles of BUSY=1.
  - START with NSHIFT=0 in IDLE: no shift, no BUSY; DONE pulses next cycle.
  - NSHIFT>WIDTH is clamped to WIDTH.
  - START while BUSY is ignored.
  - MODE changes during RUN are ignored. SIN_L/SIN_R are sampled live every step.
- DONE is high for exactly one cycle. It is cleared on the next edge regardless of inputs.
- START and EN together in IDLE: START wins; EN is dropped.

Decomposition:
- Shared package shift_pkg:
  - mode encoding constants MODE_SHL=2'b00, MODE_SHR=2'b01, MODE_ROTL=2'b10, MODE_ROTR=2'b11;
  - FSM state constants ST_IDLE and ST_RUN.
- One sub-module is natural: shift_step. It is purely combinational, takes (R, mode, SIN_L, SIN_R) and produces (next R, out bit). The top instantiates it once and muxes its result for both EN and burst steps.

Test Plan:
- Reset: assert RST_N=0 asynchronously mid-cycle -> POUT=0, SOUT=0, BUSY=0, DONE=0 immediately; with WIDTH=8, LOAD PIN=8'hA5 -> POUT=8'hA5 next cycle.
- Single steps from 8'hA5: EN, MODE=shl, SIN_L=1 -> POUT=8'h4B, SOUT=1. Reload 8'hA5, EN, MODE=shr, SIN_R=0 -> POUT=8'h52, SOUT=1.
- Burst rotl of 8'hA5, START with NSHIFT=3 -> BUSY high 3 cycles with POUT 8'h4B, 8'h96, 8'h2D; DONE pulse coincides with BUSY falling; SOUT=1; MODE toggled during RUN has no effect.
- Abort: START with NSHIFT=8, then LOAD PIN=8'h3C on the 2nd BUSY cycle -> POUT=8'h3C, BUSY=0, DONE never asserted.
- Edge counts: NSHIFT=0 -> no BUSY, POUT unchanged, DONE single pulse. NSHIFT=9 (clamped) on rotl of 8'hA5 -> 8 BUSY cycles, final POUT=8'hA5.
- Conflicts: START asserted again while BUSY -> ignored, burst length unchanged. START+EN together in IDLE -> only the burst runs. RST_N low mid-burst -> all outputs 0, no DONE after release.
